// File: rtl/ahb_burst_addr_gen.sv
// AHB-Lite master address-phase engine: expands one burst command into per-beat
// HADDR/HTRANS/HBURST/HSIZE/HWRITE with BUSY insertion, 1KB splitting and ERROR abort.
module ahb_burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LENGTH     = 4
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_burst,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_write,
  input  logic [LENGTH-1:0]     cmd_len,
  input  logic [2**LENGTH-1:0]  cmd_busy_mask,
  input  logic                  hready,
  input  logic                  hresp,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic [2:0]            hburst,
  output logic [2:0]            hsize,
  output logic                  hwrite,
  output logic                  burst_done,
  output logic                  burst_err,
  output logic                  cmd_err
);

  localparam int unsigned MaxBeats = 2 ** LENGTH;
  localparam logic [2:0]  MaxSize  = 3'($clog2(DATA_WIDTH / 8));

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrBusy   = 2'b01;
  localparam logic [1:0] TrNonseq = 2'b10;
  localparam logic [1:0] TrSeq    = 2'b11;

  localparam logic [2:0] BurstSingle = 3'b000;
  localparam logic [2:0] BurstIncr   = 3'b001;

  typedef enum logic [2:0] {StIdle, StAddr, StBusy, StDrain, StErr} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [ADDR_WIDTH-1:0] wrap_mask_q;
  logic [1:0]            htrans_q;
  logic [2:0]            hburst_q;
  logic [2:0]            hsize_q;
  logic                  hwrite_q;
  logic                  burst_done_q;
  logic                  burst_err_q;
  logic                  cmd_err_q;
  logic [LENGTH-1:0]     beat_q;
  logic [LENGTH-1:0]     last_q;
  logic [MaxBeats-1:0]   busy_q;
  logic                  cross_q;
  logic                  dp_valid_q;
  logic                  dp_last_q;

  // Command decode
  logic [LENGTH-1:0]     cmd_last;
  logic [ADDR_WIDTH-1:0] cmd_step;
  logic [ADDR_WIDTH-1:0] cmd_total;
  logic [ADDR_WIDTH-1:0] cmd_aligned;
  logic [ADDR_WIDTH-1:0] cmd_wmask;
  logic [ADDR_WIDTH-1:0] cmd_lo;
  logic [ADDR_WIDTH-1:0] cmd_hi;
  logic                  cmd_is_wrap;
  logic                  cmd_cross;
  logic                  cmd_size_bad;

  always_comb begin
    cmd_last = '0;
    case (cmd_burst)
      BurstSingle:    cmd_last = '0;
      BurstIncr:      cmd_last = cmd_len;
      3'b010, 3'b011: cmd_last = LENGTH'(3);
      3'b100, 3'b101: cmd_last = LENGTH'(7);
      default:        cmd_last = LENGTH'(15);
    endcase
    cmd_step     = ADDR_WIDTH'(1) << cmd_size;
    cmd_total    = (ADDR_WIDTH'(cmd_last) + ADDR_WIDTH'(1)) << cmd_size;
    cmd_aligned  = cmd_addr & ~(cmd_step - ADDR_WIDTH'(1));
    cmd_is_wrap  = ~cmd_burst[0] & (cmd_burst != BurstSingle);
    // INCR-type bursts use an all-ones mask so the wrap formula reduces to addr + step.
    cmd_wmask    = cmd_is_wrap ? cmd_total - ADDR_WIDTH'(1) : '1;
    cmd_lo       = cmd_is_wrap ? (cmd_aligned & ~cmd_wmask) : cmd_aligned;
    cmd_hi       = cmd_lo + cmd_total - ADDR_WIDTH'(1);
    cmd_cross    = (cmd_burst != BurstIncr) && (((cmd_lo ^ cmd_hi) >> 10) != '0);
    cmd_size_bad = cmd_size > MaxSize;
  end

  // Next-beat address
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  next_cross;
  logic                  err_first;
  logic                  err_second;

  always_comb begin
    step       = ADDR_WIDTH'(1) << hsize_q;
    incr_addr  = haddr_q + step;
    next_addr  = (haddr_q & ~wrap_mask_q) | (incr_addr & wrap_mask_q);
    next_cross = (hburst_q == BurstIncr) && (((next_addr ^ haddr_q) >> 10) != '0);
    err_first  = dp_valid_q & hresp & ~hready;
    err_second = dp_valid_q & hresp & hready;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= StIdle;
      haddr_q      <= '0;
      wrap_mask_q  <= '0;
      htrans_q     <= TrIdle;
      hburst_q     <= BurstSingle;
      hsize_q      <= '0;
      hwrite_q     <= 1'b0;
      burst_done_q <= 1'b0;
      burst_err_q  <= 1'b0;
      cmd_err_q    <= 1'b0;
      beat_q       <= '0;
      last_q       <= '0;
      busy_q       <= '0;
      cross_q      <= 1'b0;
      dp_valid_q   <= 1'b0;
      dp_last_q    <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      burst_err_q  <= 1'b0;
      cmd_err_q    <= 1'b0;

      // A NONSEQ/SEQ address accepted with hready opens a tracked data phase.
      if (hready) begin
        dp_valid_q <= htrans_q[1];
        dp_last_q  <= (beat_q == last_q);
      end

      if (state_q == StIdle) begin
        if (cmd_valid) begin
          if (cmd_size_bad || cmd_cross) begin
            cmd_err_q <= 1'b1;
          end else begin
            haddr_q     <= cmd_aligned;
            wrap_mask_q <= cmd_wmask;
            htrans_q    <= TrNonseq;
            hburst_q    <= cmd_burst;
            hsize_q     <= cmd_size;
            hwrite_q    <= cmd_write;
            beat_q      <= '0;
            last_q      <= cmd_last;
            busy_q      <= cmd_busy_mask;
            cross_q     <= 1'b0;
            state_q     <= StAddr;
          end
        end
      end else if (err_second || (state_q == StErr && hready)) begin
        htrans_q    <= TrIdle;
        burst_err_q <= 1'b1;
        dp_valid_q  <= 1'b0;
        state_q     <= StIdle;
      end else if (err_first) begin
        htrans_q <= TrIdle;
        state_q  <= StErr;
      end else if (hready) begin
        case (state_q)
          StAddr: begin
            if (beat_q == last_q) begin
              htrans_q <= TrIdle;
              state_q  <= StDrain;
            end else begin
              haddr_q <= next_addr;
              beat_q  <= beat_q + LENGTH'(1);
              busy_q  <= busy_q >> 1;
              if (busy_q[1]) begin
                htrans_q <= TrBusy;
                cross_q  <= next_cross;
                state_q  <= StBusy;
              end else begin
                htrans_q <= next_cross ? TrNonseq : TrSeq;
              end
            end
          end
          StBusy: begin
            htrans_q <= cross_q ? TrNonseq : TrSeq;
            state_q  <= StAddr;
          end
          StDrain: begin
            burst_done_q <= dp_valid_q & dp_last_q;
            state_q      <= StIdle;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign haddr      = haddr_q;
  assign htrans     = htrans_q;
  assign hburst     = hburst_q;
  assign hsize      = hsize_q;
  assign hwrite     = hwrite_q;
  assign burst_done = burst_done_q;
  assign burst_err  = burst_err_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_ahb_burst_addr_gen.sv
// Bench for ahb_burst_addr_gen: directed scenarios plus random bursts checked against a
// beat-list model built from burst arithmetic.
module tb_ahb_burst_addr_gen;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [2:0]  cmd_size;
  logic        cmd_write;
  logic [3:0]  cmd_len;
  logic [15:0] cmd_busy_mask;
  logic        hready;
  logic        hresp;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        burst_done;
  logic        burst_err;
  logic        cmd_err;

  int errors = 0;
  int checks = 0;

  ahb_burst_addr_gen #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LENGTH    (4)
  ) dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_burst    (cmd_burst),
    .cmd_size     (cmd_size),
    .cmd_write    (cmd_write),
    .cmd_len      (cmd_len),
    .cmd_busy_mask(cmd_busy_mask),
    .hready       (hready),
    .hresp        (hresp),
    .haddr        (haddr),
    .htrans       (htrans),
    .hburst       (hburst),
    .hsize        (hsize),
    .hwrite       (hwrite),
    .burst_done   (burst_done),
    .burst_err    (burst_err),
    .cmd_err      (cmd_err)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_haddr"}, haddr, 32'h0);
    chk({tag, "_htrans"}, 32'(htrans), 32'h0);
    chk({tag, "_hburst"}, 32'(hburst), 32'h0);
    chk({tag, "_hsize"}, 32'(hsize), 32'h0);
    chk({tag, "_hwrite"}, 32'(hwrite), 32'h0);
    chk({tag, "_done"}, 32'(burst_done), 32'h0);
    chk({tag, "_berr"}, 32'(burst_err), 32'h0);
    chk({tag, "_cerr"}, 32'(cmd_err), 32'h0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'h1);
  endtask

  // Present one command in an idle cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                       input logic w, input logic [3:0] l, input logic [15:0] m);
    @(negedge hclk);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    cmd_addr      = a;
    cmd_burst     = b;
    cmd_size      = s;
    cmd_write     = w;
    cmd_len       = l;
    cmd_busy_mask = m;
    cmd_valid     = 1'b1;
    hready        = 1'b1;
    hresp         = 1'b0;
    @(negedge hclk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                           input logic w, input logic [3:0] l, input logic [15:0] m,
                           input bit rnd, input logic [31:0] pat);
    logic [31:0] step, total, al, base, ad, prev;
    logic [1:0]  q_tr[$];
    logic [31:0] q_ad[$];
    bit          q_last[$];
    int          beats, cyc;
    bit          rej, is_wrap, hr, last_dp, done_next, done;

    // Expected address-phase items, BUSY entries included, in bus order.
    beats   = (b == 3'd0) ? 1 : (b == 3'd1) ? int'(l) + 1 : 4 << ((int'(b) - 2) / 2);
    is_wrap = (b == 3'd2) || (b == 3'd4) || (b == 3'd6);
    step    = 32'd1 << s;
    total   = step * 32'(beats);
    al      = a & ~(step - 32'd1);
    base    = al - (al % total);
    rej     = (s > 3'd2);
    prev    = al;
    for (int i = 0; i < beats; i++) begin
      if (is_wrap) ad = base + ((al - base + step * 32'(i)) % total);
      else         ad = al + step * 32'(i);
      if (b != 3'd1 && ad[31:10] != al[31:10]) rej = 1'b1;
      if (i > 0 && m[i[3:0]]) begin
        q_tr.push_back(2'b01);
        q_ad.push_back(ad);
        q_last.push_back(1'b0);
      end
      q_tr.push_back((i == 0 || (b == 3'd1 && ad[31:10] != prev[31:10])) ? 2'b10 : 2'b11);
      q_ad.push_back(ad);
      q_last.push_back(i == beats - 1);
      prev = ad;
    end

    issue(a, b, s, w, l, m);
    if (rej) begin
      chk("rej_cmd_err", 32'(cmd_err), 32'h1);
      chk("rej_htrans", 32'(htrans), 32'h0);
      @(negedge hclk);
      chk("rej_cmd_err_clr", 32'(cmd_err), 32'h0);
      chk("rej_htrans2", 32'(htrans), 32'h0);
      chk("rej_ready", 32'(cmd_ready), 32'h1);
      return;
    end

    cyc       = 0;
    last_dp   = 1'b0;
    done_next = 1'b0;
    done      = 1'b0;
    while (!done && cyc < 400) begin
      chk("burst_done", 32'(burst_done), 32'(done_next));
      chk("burst_err", 32'(burst_err), 32'h0);
      chk("cmd_err", 32'(cmd_err), 32'h0);
      if (done_next) begin
        done = 1'b1;
        chk("ready_after", 32'(cmd_ready), 32'h1);
        chk("htrans_after", 32'(htrans), 32'h0);
      end else begin
        if (q_tr.size() > 0) begin
          chk("htrans", 32'(htrans), 32'(q_tr[0]));
          chk("haddr", haddr, q_ad[0]);
          chk("hburst", 32'(hburst), 32'(b));
          chk("hsize", 32'(hsize), 32'(s));
          chk("hwrite", 32'(hwrite), 32'(w));
          chk("ready_busy", 32'(cmd_ready), 32'h0);
        end else begin
          chk("htrans_drain", 32'(htrans), 32'h0);
        end
        hr     = rnd ? ($urandom_range(0, 3) != 0) : (cyc < 32 ? !pat[cyc] : 1'b1);
        hready = hr;
        done_next = 1'b0;
        if (hr) begin
          if (last_dp) begin
            done_next = 1'b1;
            last_dp   = 1'b0;
          end
          if (q_tr.size() > 0) begin
            if (q_last[0]) last_dp = 1'b1;
            void'(q_tr.pop_front());
            void'(q_ad.pop_front());
            void'(q_last.pop_front());
          end
        end
        @(negedge hclk);
        cyc++;
      end
    end
    if (!done) chk("burst_timeout", 32'h0, 32'h1);
    hready = 1'b1;
  endtask

  // INCR8 WORD, zero waits, ERROR on beat 2's data phase (while beat 3 is presented).
  task automatic error_test(input logic [31:0] a);
    issue(a, 3'b101, 3'd2, 1'b1, 4'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("err_beat_addr", haddr, a + 32'(4 * i));
      chk("err_beat_trans", 32'(htrans), (i == 0) ? 32'h2 : 32'h3);
      hready = 1'b1;
      @(negedge hclk);
    end
    chk("err_beat3_addr", haddr, a + 32'd12);
    chk("err_beat3_trans", 32'(htrans), 32'h3);
    hresp  = 1'b1;
    hready = 1'b0;
    @(negedge hclk);
    chk("err_idle_2nd", 32'(htrans), 32'h0);
    chk("err_no_pulse_yet", 32'(burst_err), 32'h0);
    hresp  = 1'b1;
    hready = 1'b1;
    @(negedge hclk);
    hresp = 1'b0;
    chk("err_pulse", 32'(burst_err), 32'h1);
    chk("err_no_done", 32'(burst_done), 32'h0);
    chk("err_ready", 32'(cmd_ready), 32'h1);
    chk("err_htrans", 32'(htrans), 32'h0);
    @(negedge hclk);
    chk("err_pulse_once", 32'(burst_err), 32'h0);
    chk("err_htrans_after", 32'(htrans), 32'h0);
    chk("err_no_done_after", 32'(burst_done), 32'h0);
  endtask

  task automatic reset_test(input logic [31:0] a);
    issue(a, 3'b110, 3'd2, 1'b1, 4'd0, 16'h0);
    chk("rst_first_beat", 32'(htrans), 32'h2);
    repeat (5) begin
      hready = 1'b1;
      @(negedge hclk);
    end
    chk("rst_mid_trans", 32'(htrans), 32'h3);
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    check_idle("rst_mid");
    @(negedge hclk);
    check_idle("rst_after");
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rs;
    hreset        = 1'b1;
    cmd_valid     = 1'b0;
    cmd_addr      = '0;
    cmd_burst     = '0;
    cmd_size      = '0;
    cmd_write     = 1'b0;
    cmd_len       = '0;
    cmd_busy_mask = '0;
    hready        = 1'b1;
    hresp         = 1'b0;
    repeat (2) @(negedge hclk);
    check_idle("in_reset");
    hreset = 1'b0;
    @(negedge hclk);
    check_idle("post_reset");

    run_burst(32'h100, 3'b011, 3'd2, 1'b1, 4'd0, 16'h0, 1'b0, 32'h0);
    run_burst(32'h38, 3'b010, 3'd2, 1'b0, 4'd0, 16'h0, 1'b0, 32'h0);
    run_burst(32'h1C, 3'b100, 3'd1, 1'b0, 4'd0, 16'h0, 1'b0, 32'h0);
    run_burst(32'h3F8, 3'b001, 3'd2, 1'b1, 4'd3, 16'h0, 1'b0, 32'h0);
    run_burst(32'h3F0, 3'b101, 3'd2, 1'b1, 4'd0, 16'h0, 1'b0, 32'h0);
    run_burst(32'h100, 3'b011, 3'd2, 1'b1, 4'd0, 16'h0004, 1'b0, 32'h0000_000E);
    error_test(32'h200);
    error_test(($urandom() & ~32'h3FF) | 32'h100);
    reset_test(32'h400);
    run_burst(32'h40, 3'b000, 3'd3, 1'b0, 4'd0, 16'h0, 1'b0, 32'h0);
    run_burst(32'h3FE, 3'b001, 3'd1, 1'b0, 4'd7, 16'hFFFF, 1'b1, 32'h0);

    for (int n = 0; n < 60; n++) begin
      ra = $urandom();
      if ($urandom_range(0, 1) == 1) ra = (ra & ~32'h3FF) | (32'h3C0 + 32'($urandom_range(0, 63)));
      rs = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      run_burst(ra, 3'($urandom_range(0, 7)), rs, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 16'($urandom()), 1'b1, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_burst_addr_gen.md
Name: ahb_burst_addr_gen

Overview:
Parametrised AHB-Lite master address-phase engine. Takes one burst command and drives HADDR/HTRANS/HBURST/HSIZE/HWRITE for every beat. Supports all eight HBURST encodings, undefined-length INCR, programmable BUSY insertion, wait states, 1KB-boundary splitting and two-cycle ERROR abort. Sits between the master driver BFM and the AHB interface, and also serves as the synthesizable master-side reference for the slave agent.

Parameters:
ADDR_WIDTH, 32, HADDR width.
DATA_WIDTH, 32, bus width. Maximum legal HSIZE is log2(DATA_WIDTH/8).
LENGTH, 4, log2 of maximum beats. MAX_BEATS = 2**LENGTH (16).

Ports:
hclk  in  1  bus clock.
hreset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high when the engine is idle and can accept a command.
cmd_addr  in  ADDR_WIDTH  start address.
cmd_burst  in  3  HBURST encoding (SINGLE=000 … INCR16=111).
cmd_size  in  3  HSIZE encoding.
cmd_write  in  1  1 = write.
cmd_len  in  LENGTH  beats minus 1. Used only for INCR (001).
cmd_busy_mask  in  MAX_BEATS  bit i=1 inserts one BUSY cycle before beat i. Bit 0 is ignored.
hready  in  1  combined transfer-complete.
hresp  in  1  0 = OKAY, 1 = ERROR.
haddr  out  ADDR_WIDTH  address.
htrans  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
hburst  out  3  burst type.
hsize  out  3  transfer size.
hwrite  out  1  direction.
burst_done  out  1  one-cycle pulse when the last beat's data phase completes with OKAY.
burst_err  out  1  one-cycle pulse when the burst is aborted by ERROR.
cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Clocking and reset:
  - Single clock hclk. Reset is synchronous and active-high (hreset). All state changes on the rising edge of hclk.
  - Reset values: haddr=0, htrans=IDLE, hburst=SINGLE, hsize=0, hwrite=0, all pulses=0, state=IDLE.
  - cmd_ready is combinational (state==IDLE) and reads 1 during and after reset.
  - hreset asserted mid-burst forces IDLE outputs on the next edge. Beats in flight are dropped without done/err pulses.
- Outputs are registered. Address-phase outputs advance only on an edge where hready=1. When hready=0 they hold, except for the error rule below.
- Command acceptance: a command is accepted when cmd_valid & cmd_ready.
  - If cmd_size > log2(DATA_WIDTH/8): cmd_err pulses on the next cycle and no transfer is issued.
  - Otherwise the start address is aligned by clearing bits [cmd_size-1:0].
- Beat count:
  - SINGLE: 1.
  - INCR: cmd_len+1.
  - WRAP4/INCR4: 4. WRAP8/INCR8: 8. WRAP16/INCR16: 16.
- Address arithmetic (modulo 2**ADDR_WIDTH):
  - step = 1 << hsize.
  - INCR-type bursts: next = addr + step.
  - WRAP-type bursts: m = beats*step - 1; next = (addr & ~m) | ((addr + step) & m).
- State machine:
  - IDLE: on accept → ADDR. The first beat is driven NONSEQ on the next cycle.
  - ADDR: beat k is presented. When hready=1:
    - If k is the last beat → DRAIN.
    - Else if cmd_busy_mask[k+1]=1 → BUSY. htrans=BUSY, haddr=next address, hburst/hsize unchanged.
    - Else present beat k+1 as SEQ.
  - BUSY: on hready=1 present beat k+1 as SEQ → ADDR. BUSY occurs at most once per beat.
  - DRAIN: htrans=IDLE. When the last data phase completes (hready=1) → burst_done, then IDLE.
  - A new command is accepted only in IDLE. There is no back-to-back pipelining.
- 1KB rule:
  - Applies to INCR (001) only. If next crosses a 1KB boundary (next[ADDR_WIDTH-1:10] != addr[ADDR_WIDTH-1:10]), that beat is issued as NONSEQ instead of SEQ.
  - For fixed-length bursts, if the start address would cause a crossing, the command is rejected via cmd_err.
- Data-phase tracker: a registered flag records that a non-IDLE/non-BUSY beat is in its data phase, plus whether it is the last beat.
- Error abort:
  - hresp=1 & hready=0 (first ERROR cycle) in a data phase: htrans is driven IDLE from the next edge, even though hready=0. Remaining beats are dropped.
  - On hresp=1 & hready=1 (second ERROR cycle): burst_err pulses next cycle, state → IDLE, burst_done is not asserted.
- Simultaneous events: an error and the last beat completing in the same cycle → burst_err only.

Test Plan:
1. INCR4, WORD, 0x100, no waits → haddr 0x100/0x104/0x108/0x10C; htrans NONSEQ,SEQ,SEQ,SEQ; burst_done pulses one cycle after the last data phase completes.
2. WRAP4 WORD at 0x38 → 0x38,0x3C,0x30,0x34. WRAP8 HALFWORD at 0x1C → 0x1C,0x1E,0x10,0x12,0x14,0x16,0x18,0x1A.
3. INCR, cmd_len=3, WORD, 0x3F8 → 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404 SEQ. INCR8 WORD at 0x3F0 → cmd_err=1 and htrans stays IDLE.
4. INCR4 with cmd_busy_mask=0x0004, hready held low 3 cycles during beat 1 → beat 1 (0x104) held 3 cycles; then BUSY at haddr 0x108; then 0x108 SEQ, 0x10C SEQ.
5. INCR8 with hresp=ERROR on beat 2's data phase → htrans=IDLE from the second ERROR cycle; burst_err pulses once; no beats issued beyond beat 3; cmd_ready=1 afterwards.
6. hreset pulsed mid-WRAP16; SINGLE cmd_size=3 with DATA_WIDTH=32 → all outputs at reset values next cycle, no pulses; the SINGLE command is rejected with cmd_err.
